// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered read port, registered status flags
// and sticky overflow/underflow error flags.
module sync_fifo_param #(
  parameter int WIDTH         = 16,
  parameter int DEPTH         = 32,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  input  logic                   err_clr_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   rd_valid_o,
  output logic                   wr_full_o,
  output logic                   rd_empty_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] AE_L    = LW'(AEMPTY_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_full_q, wr_full_d;
  logic             rd_empty_q, rd_empty_d;
  logic             almost_full_q, almost_full_d;
  logic             almost_empty_q, almost_empty_d;

  logic             wr_accept;
  logic             rd_accept;

  // Request/accept semantics: wr_en/rd_en are requests, not handshakes.
  // A read is accepted whenever the FIFO is non-empty; a write is accepted
  // when not full, or when full but a read is accepted in the same cycle.
  // Requests that are not accepted are dropped and flagged as errors;
  // during rst or flush requests are ignored without error.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_accept   = 1'b0;
    rd_accept   = 1'b0;

    if (rst_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      if (err_clr_i) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end
    end else begin
      rd_accept = rd_en_i && !rd_empty_q;
      wr_accept = wr_en_i && (!wr_full_q || rd_accept);

      if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);
      rd_valid_d = rd_accept;

      case ({wr_accept, rd_accept})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase

      // A fresh error in the same cycle as err_clr wins.
      overflow_d  = (overflow_q  && !err_clr_i) || (wr_en_i && !wr_accept);
      underflow_d = (underflow_q && !err_clr_i) || (rd_en_i && !rd_accept);
    end

    wr_full_d      = (level_d == DEPTH_L);
    rd_empty_d     = (level_d == '0);
    almost_full_d  = (level_d >= AF_L);
    almost_empty_d = (level_d <= AE_L);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      rd_valid_q     <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      wr_full_q      <= 1'b0;
      rd_empty_q     <= 1'b1;
      almost_full_q  <= (AF_L == '0);
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      rd_valid_q     <= rd_valid_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      wr_full_q      <= wr_full_d;
      rd_empty_q     <= rd_empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  // Storage has no reset so it can map onto RAM; reads see pre-edge contents,
  // which keeps a simultaneous write/read on a full FIFO ordered correctly.
  always_ff @(posedge clk_i) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_accept) begin
      rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  assign rd_data_o      = rd_data_q;
  assign rd_valid_o     = rd_valid_q;
  assign wr_full_o      = wr_full_q;
  assign rd_empty_o     = rd_empty_q;
  assign level_o        = level_q;
  assign almost_full_o  = almost_full_q;
  assign almost_empty_o = almost_empty_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: vector table, directed corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int W  = 16;
  localparam int D  = 32;
  localparam int AF = 28;
  localparam int AE = 4;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst, flush, wr_en, rd_en, err_clr;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  rd_data;
  logic          rd_valid, wr_full, rd_empty, almost_full, almost_empty;
  logic          overflow, underflow;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_rd_data;
  logic         m_rd_valid, m_ovf, m_unf;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .err_clr_i(err_clr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .wr_full_o(wr_full), .rd_empty_o(rd_empty), .level_o(level),
    .almost_full_o(almost_full), .almost_empty_o(almost_empty),
    .overflow_o(overflow), .underflow_o(underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic f, input logic w, input logic [W-1:0] d,
                              input logic r, input logic c);
    logic rd_ok, wr_ok;
    if (f) begin
      exp_q.delete();
      m_rd_valid = 1'b0;
      if (c) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
    end else begin
      rd_ok = r && (exp_q.size() > 0);
      wr_ok = w && ((exp_q.size() < D) || rd_ok);
      m_ovf = (m_ovf && !c) || (w && !wr_ok);
      m_unf = (m_unf && !c) || (r && !rd_ok);
      m_rd_valid = rd_ok;
      if (rd_ok) m_rd_data = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(d);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = exp_q.size();
    chk({tag, ".level"},        32'(level),        32'(n));
    chk({tag, ".wr_full"},      32'(wr_full),      32'(n == D));
    chk({tag, ".rd_empty"},     32'(rd_empty),     32'(n == 0));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(n >= AF));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    chk({tag, ".rd_valid"},     32'(rd_valid),     32'(m_rd_valid));
    chk({tag, ".rd_data"},      32'(rd_data),      32'(m_rd_data));
    chk({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
    chk({tag, ".underflow"},    32'(underflow),    32'(m_unf));
  endtask

  // Inputs change at posedge+1, DUT is sampled at the following posedge+1.
  task automatic step(input string tag, input logic f, input logic w, input logic [W-1:0] d,
                      input logic r, input logic c);
    flush = f; wr_en = w; wr_data = d; rd_en = r; err_clr = c;
    @(posedge clk);
    model_update(f, w, d, r, c);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; flush = 1'b0; wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'h5555; err_clr = 1'b0;
    @(posedge clk);
    exp_q.delete();
    m_rd_data = '0; m_rd_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check_model(tag);
  endtask

  typedef struct {
    logic         f, w;
    logic [W-1:0] d;
    logic         r, c;
    logic [LW-1:0] lvl;
    logic         rv;
    logic [W-1:0] rdat;
    logic         ovf, unf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int wp, rp;
    logic [W-1:0] d;

    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; err_clr = 1'b0;
    m_rd_data = '0; m_rd_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    //               f  w  data     r  c  lvl rv rdat     ovf unf
    vecs[0] = '{1'b0, 1'b1, 16'h00AA, 1'b1, 1'b0, 6'd1, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 6'd0, 1'b1, 16'h00AA, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 6'd0, 1'b0, 16'h00AA, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 6'd0, 1'b0, 16'h00AA, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 6'd1, 1'b0, 16'h00AA, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 16'h0022, 1'b0, 1'b0, 6'd2, 1'b0, 16'h00AA, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 16'h0033, 1'b1, 1'b0, 6'd0, 1'b0, 16'h00AA, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 6'd0, 1'b0, 16'h00AA, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 6'd0, 1'b0, 16'h00AA, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 6'd0, 1'b0, 16'h00AA, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    do_reset("reset0");

    for (int i = 0; i < 10; i++) begin
      step("vec", vecs[i].f, vecs[i].w, vecs[i].d, vecs[i].r, vecs[i].c);
      chk($sformatf("vec%0d.level", i),     32'(level),     32'(vecs[i].lvl));
      chk($sformatf("vec%0d.rd_valid", i),  32'(rd_valid),  32'(vecs[i].rv));
      chk($sformatf("vec%0d.rd_data", i),   32'(rd_data),   32'(vecs[i].rdat));
      chk($sformatf("vec%0d.overflow", i),  32'(overflow),  32'(vecs[i].ovf));
      chk($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(vecs[i].unf));
    end

    // Fill to full, then overflow
    do_reset("reset1");
    for (int i = 0; i < D; i++) begin
      step("fill", 1'b0, 1'b1, W'(i), 1'b0, 1'b0);
      if (i == AF - 2) chk("fill.af_below", 32'(almost_full), 32'd0);
      if (i == AF - 1) chk("fill.af_at",    32'(almost_full), 32'd1);
    end
    chk("full.wr_full", 32'(wr_full), 32'd1);
    chk("full.level",   32'(level),   32'd32);
    step("ovf", 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    chk("ovf.overflow", 32'(overflow), 32'd1);
    chk("ovf.level",    32'(level),    32'd32);

    // Drain in order, then underflow
    for (int i = 0; i < D; i++) begin
      step("drain", 1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("drain.rd_valid", 32'(rd_valid), 32'd1);
      chk("drain.rd_data",  32'(rd_data),  32'(i));
    end
    chk("drain.rd_empty", 32'(rd_empty), 32'd1);
    chk("drain.level",    32'(level),    32'd0);
    step("unf", 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("unf.underflow", 32'(underflow), 32'd1);
    chk("unf.rd_valid",  32'(rd_valid),  32'd0);
    chk("unf.rd_data",   32'(rd_data),   32'h001F);

    // Full FIFO streaming across two pointer wraps
    step("clr", 1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < D; i++) step("refill", 1'b0, 1'b1, W'(16'h0100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 2 * D; i++) begin
      step("stream", 1'b0, 1'b1, W'(16'h0200 + i), 1'b1, 1'b0);
      chk("stream.level",    32'(level),    32'd32);
      chk("stream.overflow", 32'(overflow), 32'd0);
      chk("stream.rd_data",  32'(rd_data),
          (i < D) ? 32'(16'h0100 + i) : 32'(16'h0200 + i - D));
    end

    // Simultaneous write/read on empty
    for (int i = 0; i < D; i++) step("empty_out", 1'b0, 1'b0, '0, 1'b1, 1'b0);
    step("clr2", 1'b0, 1'b0, '0, 1'b0, 1'b1);
    step("wr_rd_empty", 1'b0, 1'b1, 16'h00AA, 1'b1, 1'b0);
    chk("wr_rd_empty.level",     32'(level),     32'd1);
    chk("wr_rd_empty.underflow", 32'(underflow), 32'd1);
    chk("wr_rd_empty.rd_valid",  32'(rd_valid),  32'd0);
    step("rd_aa", 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("rd_aa.rd_data", 32'(rd_data), 32'h00AA);

    // Flush at level 10 keeps sticky flags, err_clr then clears them
    for (int i = 0; i < 10; i++) step("lvl10", 1'b0, 1'b1, W'(i), 1'b0, 1'b0);
    chk("lvl10.level", 32'(level), 32'd10);
    step("flush", 1'b1, 1'b1, 16'h7777, 1'b0, 1'b0);
    chk("flush.level",     32'(level),     32'd0);
    chk("flush.rd_empty",  32'(rd_empty),  32'd1);
    chk("flush.overflow",  32'(overflow),  32'd0);
    chk("flush.underflow", 32'(underflow), 32'd1);
    step("errclr", 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("errclr.underflow", 32'(underflow), 32'd0);

    // Reset mid-operation
    for (int i = 0; i < 20; i++) step("lvl20", 1'b0, 1'b1, W'(i), 1'b0, 1'b0);
    step("ovf_pre", 1'b0, 1'b0, '0, 1'b0, 1'b0);
    do_reset("reset_mid");
    chk("reset_mid.level",        32'(level),        32'd0);
    chk("reset_mid.rd_data",      32'(rd_data),      32'd0);
    chk("reset_mid.almost_empty", 32'(almost_empty), 32'd1);
    step("wr1234", 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
    step("rd1234", 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("rd1234.rd_data",  32'(rd_data),  32'h1234);
    chk("rd1234.rd_valid", 32'(rd_valid), 32'd1);

    // Randomized traffic in phases biased toward full, empty and balanced
    for (int ph = 0; ph < 8; ph++) begin
      wp = (ph % 4 == 0) ? 85 : (ph % 4 == 1) ? 15 : (ph % 4 == 2) ? 50 : 95;
      rp = 100 - wp + ((ph % 2) * 10);
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 199) == 0) begin
          do_reset("rnd_rst");
        end else begin
          d = W'($urandom);
          step("rnd",
               ($urandom_range(0, 99) < 2),
               ($urandom_range(0, 99) < wp), d,
               ($urandom_range(0, 99) < rp),
               ($urandom_range(0, 99) < 5));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
